// File: rtl/keypad_regfile_alu.sv
// 4x4 keypad scanner with debounce, hex-digit shift register file and registered ALU.
// Optional build macro KPALU_MUL_EN turns op 3'b111 from PASS into an unsigned multiply.
module keypad_regfile_alu #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [3:0]        col_sense_i,
    output logic [3:0]        row_drive_o,
    output logic              key_valid_o,
    output logic [3:0]        key_code_o,
    input  logic              wr_en_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [AW-1:0]     addr_a_i,
    input  logic [AW-1:0]     addr_b_i,
    input  logic [2:0]        op_sel_i,
    input  logic              op_start_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic              ovf_o
);

    // state       | meaning
    // ST_SCAN     | rotate rows, wait for any column return
    // ST_DEBOUNCE | row frozen, counting identical samples of the latched column
    // ST_HOLD     | key accepted, row frozen until DEBOUNCE zero samples
    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD} scan_state_t;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    scan_state_t       state_q;
    logic [3:0]        col_s1_q, col_s2_q;
    logic [3:0]        row_q;
    logic [3:0]        sample_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              key_valid_q;
    logic [3:0]        key_code_q;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W:0]   sum_w, dif_w;
    logic [DATA_W-1:0] alu_res_d;
    logic              alu_c_d, alu_v_d;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q, carry_q, zero_q, ovf_q;

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_SCAN;
            col_s1_q    <= '0;
            col_s2_q    <= '0;
            row_q       <= 4'b0001;
            sample_q    <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            col_s1_q    <= col_sense_i;
            col_s2_q    <= col_s1_q;
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (col_s2_q != 4'b0000) begin
                        sample_q <= col_s2_q;
                        cnt_q    <= '0;
                        div_q    <= '0;
                        state_q  <= ST_DEBOUNCE;
                    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                        div_q <= '0;
                        row_q <= {row_q[2:0], row_q[3]};
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s2_q == 4'b0000) begin
                        state_q <= ST_SCAN;
                    end else if (col_s2_q != sample_q) begin
                        sample_q <= col_s2_q;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= {low_idx(row_q), low_idx(sample_q)};
                        cnt_q       <= '0;
                        state_q     <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (col_s2_q != 4'b0000) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_SCAN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    // Each accepted key becomes the new low hex digit; the top digit falls off.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (clr_i) begin
            regs_q[wr_addr_i] <= '0;
        end else if (key_valid_q && wr_en_i) begin
            regs_q[wr_addr_i] <= DATA_W'({regs_q[wr_addr_i], key_code_q});
        end
    end

    assign op_a = regs_q[addr_a_i];
    assign op_b = regs_q[addr_b_i];

`ifdef KPALU_MUL_EN
    logic [2*DATA_W-1:0] prod_w;
    assign prod_w = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
`endif

    always_comb begin
        sum_w     = {1'b0, op_a} + {1'b0, op_b};
        dif_w     = {1'b0, op_a} - {1'b0, op_b};
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        case (op_sel_i)
            3'b000: begin
                alu_res_d = sum_w[DATA_W-1:0];
                alu_c_d   = sum_w[DATA_W];
                alu_v_d   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                            (sum_w[DATA_W-1] != op_a[DATA_W-1]);
            end
            3'b001: begin
                alu_res_d = dif_w[DATA_W-1:0];
                alu_c_d   = ~dif_w[DATA_W];
                alu_v_d   = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                            (dif_w[DATA_W-1] != op_a[DATA_W-1]);
            end
            3'b010: alu_res_d = op_a & op_b;
            3'b011: alu_res_d = op_a | op_b;
            3'b100: alu_res_d = op_a ^ op_b;
            3'b101: begin
                alu_res_d = {op_a[DATA_W-2:0], 1'b0};
                alu_c_d   = op_a[DATA_W-1];
            end
            3'b110: begin
                alu_res_d = {1'b0, op_a[DATA_W-1:1]};
                alu_c_d   = op_a[0];
            end
            3'b111: begin
`ifdef KPALU_MUL_EN
                alu_res_d = prod_w[DATA_W-1:0];
                alu_c_d   = |prod_w[2*DATA_W-1:DATA_W];
`else
                alu_res_d = op_a;
`endif
            end
            default: alu_res_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b1;
            ovf_q          <= 1'b0;
        end else begin
            result_valid_q <= op_start_i;
            if (op_start_i) begin
                result_q <= alu_res_d;
                carry_q  <= alu_c_d;
                ovf_q    <= alu_v_d;
                zero_q   <= (alu_res_d == '0);
            end
        end
    end

    assign row_drive_o    = row_q;
    assign key_valid_o    = key_valid_q;
    assign key_code_o     = key_code_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign carry_o        = carry_q;
    assign zero_o         = zero_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_keypad_regfile_alu.sv
// Bench for keypad_regfile_alu: behavioural model compared every cycle plus literal spot checks.
module tb_keypad_regfile_alu;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int SCAN_DIV = 16;
    localparam int DEBOUNCE = 4;
    localparam int AW       = 2;
    localparam int MASK     = (1 << DATA_W) - 1;
    localparam int HALF     = 1 << (DATA_W - 1);

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic [3:0]        col_sense_i = '0;
    logic [3:0]        row_drive_o;
    logic              key_valid_o;
    logic [3:0]        key_code_o;
    logic              wr_en_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [AW-1:0]     wr_addr_i = '0;
    logic [AW-1:0]     addr_a_i = '0;
    logic [AW-1:0]     addr_b_i = '0;
    logic [2:0]        op_sel_i = '0;
    logic              op_start_i = 1'b0;
    logic [DATA_W-1:0] result_o;
    logic              result_valid_o;
    logic              carry_o;
    logic              zero_o;
    logic              ovf_o;

    keypad_regfile_alu #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .col_sense_i(col_sense_i),
        .row_drive_o(row_drive_o), .key_valid_o(key_valid_o), .key_code_o(key_code_o),
        .wr_en_i(wr_en_i), .clr_i(clr_i), .wr_addr_i(wr_addr_i),
        .addr_a_i(addr_a_i), .addr_b_i(addr_b_i), .op_sel_i(op_sel_i),
        .op_start_i(op_start_i), .result_o(result_o), .result_valid_o(result_valid_o),
        .carry_o(carry_o), .zero_o(zero_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int kv_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: what a keypad-reading, hex-shifting calculator must show.
    int m_reg [NUM_REGS] = '{default: 0};
    int m_in1 = 0, m_in2 = 0;
    int m_row = 0, m_tick = 0;
    bit m_frozen = 0, m_accepted = 0;
    int m_cand = 0, m_run = 0, m_zero = 0;
    int m_kv = 0, m_kc = 0;
    int m_res = 0, m_rv = 0, m_c = 0, m_z = 1, m_v = 0;

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - (MASK + 1) : x;
    endfunction

    always @(posedge clk_i) begin : model
        int s, a, b, sr, lo;
        longint p;
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) m_reg[i] = 0;
            m_in1 = 0; m_in2 = 0; m_row = 0; m_tick = 0;
            m_frozen = 0; m_accepted = 0; m_cand = 0; m_run = 0; m_zero = 0;
            m_kv = 0; m_kc = 0;
            m_res = 0; m_rv = 0; m_c = 0; m_z = 1; m_v = 0;
        end else begin
            m_rv = op_start_i;
            if (op_start_i) begin
                a = m_reg[addr_a_i];
                b = m_reg[addr_b_i];
                m_c = 0;
                m_v = 0;
                case (op_sel_i)
                    3'd0: begin
                        m_res = (a + b) & MASK; m_c = (a + b) > MASK;
                        sr = sgn(a) + sgn(b); m_v = (sr >= HALF) || (sr < -HALF);
                    end
                    3'd1: begin
                        m_res = (a - b) & MASK; m_c = (a >= b);
                        sr = sgn(a) - sgn(b); m_v = (sr >= HALF) || (sr < -HALF);
                    end
                    3'd2: m_res = a & b;
                    3'd3: m_res = a | b;
                    3'd4: m_res = a ^ b;
                    3'd5: begin m_res = (a * 2) & MASK; m_c = (a >= HALF); end
                    3'd6: begin m_res = a / 2; m_c = a % 2; end
                    default: begin
`ifdef KPALU_MUL_EN
                        p = longint'(a) * longint'(b);
                        m_res = int'(p & MASK); m_c = (p > MASK);
`else
                        m_res = a;
`endif
                    end
                endcase
                m_z = (m_res == 0);
            end
            if (clr_i) m_reg[wr_addr_i] = 0;
            else if (m_kv != 0 && wr_en_i) m_reg[wr_addr_i] = (m_reg[wr_addr_i] * 16 + m_kc) & MASK;

            s = m_in2; m_in2 = m_in1; m_in1 = col_sense_i;
            m_kv = 0;
            if (!m_frozen) begin
                if (s != 0) begin
                    m_frozen = 1; m_cand = s; m_run = 1; m_tick = 0;
                end else begin
                    m_tick++;
                    if (m_tick == SCAN_DIV) begin m_tick = 0; m_row = (m_row + 1) % 4; end
                end
            end else if (!m_accepted) begin
                if (s == 0) m_frozen = 0;
                else if (s != m_cand) begin m_cand = s; m_run = 1; end
                else begin
                    m_run++;
                    if (m_run == DEBOUNCE + 1) begin
                        lo = 0;
                        for (int i = 3; i >= 0; i--) if (((m_cand >> i) & 1) != 0) lo = i;
                        m_kv = 1; m_kc = m_row * 4 + lo; m_accepted = 1; m_zero = 0;
                    end
                end
            end else begin
                if (s == 0) begin
                    m_zero++;
                    if (m_zero == DEBOUNCE) begin m_frozen = 0; m_accepted = 0; end
                end else m_zero = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (key_valid_o === 1'b1) kv_cnt++;
        check("row_drive", 32'(row_drive_o), 32'(1 << m_row));
        check("key_valid", 32'(key_valid_o), 32'(m_kv));
        check("key_code", 32'(key_code_o), 32'(m_kc));
        check("result", 32'(result_o), 32'(m_res));
        check("result_valid", 32'(result_valid_o), 32'(m_rv));
        check("carry", 32'(carry_o), 32'(m_c));
        check("zero", 32'(zero_o), 32'(m_z));
        check("ovf", 32'(ovf_o), 32'(m_v));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic press(input int code);
        int row, lim;
        row = code >> 2;
        lim = 0;
        while (!(m_row == row && m_tick < SCAN_DIV - 4 && !m_frozen) && lim < 8 * SCAN_DIV) begin
            tick(1);
            lim++;
        end
        check("row_wait", 32'(lim < 8 * SCAN_DIV), 32'd1);
        col_sense_i = 4'(1 << (code & 3));
        tick(DEBOUNCE + 3);
        col_sense_i = 4'b0000;
        tick(DEBOUNCE + 4);
    endtask

    task automatic alu(input int op, input int a, input int b);
        op_sel_i = 3'(op);
        addr_a_i = AW'(a);
        addr_b_i = AW'(b);
        op_start_i = 1'b1;
        tick(1);
        op_start_i = 1'b0;
    endtask

    task automatic clear_reg(input int r);
        wr_addr_i = AW'(r);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        tick(3);
        reset_i = 1'b0;
        check("lit_reset_row", 32'(row_drive_o), 32'h1);
        check("lit_reset_zero", 32'(zero_o), 32'd1);
        check("lit_reset_result", 32'(result_o), 32'd0);

        base = kv_cnt;
        tick(SCAN_DIV);
        check("lit_row_step", 32'(row_drive_o), 32'h2);
        tick(3 * SCAN_DIV);
        check("lit_row_wrap", 32'(row_drive_o), 32'h1);
        check("lit_idle_no_key", 32'(kv_cnt - base), 32'd0);

        base = kv_cnt;
        press(6);
        check("lit_press_once", 32'(kv_cnt - base), 32'd1);
        check("lit_key_code_6", 32'(key_code_o), 32'h6);

        base = kv_cnt;
        for (int i = 0; i < 20; i++) begin
            col_sense_i = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            tick(1);
        end
        col_sense_i = 4'b0000;
        tick(DEBOUNCE + 4);
        check("lit_bounce_none", 32'(kv_cnt - base), 32'd0);
        base = kv_cnt;
        press(4'hA);
        check("lit_stable_once", 32'(kv_cnt - base), 32'd1);

        wr_en_i = 1'b1;
        clear_reg(2);
        press(4'h3);
        press(4'hA);
        alu(3, 2, 2);
        check("lit_reg2_3A", 32'(result_o), 32'h3A);
        press(4'h5);
        alu(3, 2, 2);
        check("lit_reg2_A5", 32'(result_o), 32'hA5);
        clear_reg(2);
        alu(3, 2, 2);
        check("lit_reg2_clr", 32'(result_o), 32'h0);
        check("lit_reg2_clr_zero", 32'(zero_o), 32'd1);

        clear_reg(0); press(4'h7); press(4'hF);
        clear_reg(1); press(4'h1);
        clear_reg(3); press(4'h1); press(4'h0);
        wr_en_i = 1'b0;

        alu(0, 0, 1);
        check("lit_add_res", 32'(result_o), 32'h80);
        check("lit_add_ovf", 32'(ovf_o), 32'd1);
        check("lit_add_carry", 32'(carry_o), 32'd0);
        check("lit_add_zero", 32'(zero_o), 32'd0);
        check("lit_add_valid", 32'(result_valid_o), 32'd1);
        alu(1, 1, 1);
        check("lit_sub_res", 32'(result_o), 32'h0);
        check("lit_sub_zero", 32'(zero_o), 32'd1);
        check("lit_sub_carry", 32'(carry_o), 32'd1);

        op_start_i = 1'b1;
        op_sel_i = 3'd1; addr_a_i = 2'd1; addr_b_i = 2'd0; tick(1);
        op_sel_i = 3'd2; addr_a_i = 2'd0; addr_b_i = 2'd1; tick(1);
        op_sel_i = 3'd4; tick(1);
        op_sel_i = 3'd5; tick(1);
        op_sel_i = 3'd6; addr_a_i = 2'd1; tick(1);
        op_sel_i = 3'd0; addr_a_i = 2'd0; addr_b_i = 2'd0; tick(1);
        op_start_i = 1'b0;
        check("lit_b2b_add_res", 32'(result_o), 32'hFE);
        tick(2);

        alu(7, 3, 3);
`ifdef KPALU_MUL_EN
        check("lit_mul_res", 32'(result_o), 32'h00);
        check("lit_mul_carry", 32'(carry_o), 32'd1);
        check("lit_mul_zero", 32'(zero_o), 32'd1);
`else
        check("lit_pass_res", 32'(result_o), 32'h10);
`endif

        wr_addr_i = 2'd0;
        clr_i = 1'b1;
        alu(3, 0, 0);
        clr_i = 1'b0;
        check("lit_no_forward", 32'(result_o), 32'h7F);
        alu(3, 0, 0);
        check("lit_after_clr", 32'(result_o), 32'h0);

        alu(3, 3, 3);
        op_start_i = 1'b1;
        reset_i = 1'b1;
        tick(1);
        op_start_i = 1'b0;
        reset_i = 1'b0;
        check("lit_rst_result", 32'(result_o), 32'h0);
        check("lit_rst_valid", 32'(result_valid_o), 32'd0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
